// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg
// Shared constants and types for the fixed-point divider.
//   DEFAULT_N   : default operand/quotient width (signed two's complement)
//   DEFAULT_F   : default number of fractional bits of the Q(N-F).F format
//   div_state_t : controller states of the divider
package fixed_point_pkg;

    localparam int DEFAULT_N = 16;
    localparam int DEFAULT_F = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/fixed_point_saturate.sv
// fixed_point_saturate
// Combinational sign application and saturation of an unsigned quotient
// magnitude into the signed N-bit Q(N-F).F range.
//   magnitude   : in  [N+F-1:0] unsigned quotient magnitude from the divider
//   negative    : in  result sign (1 = negative)
//   div_by_zero : in  divisor was zero; result becomes the signed extreme
//   result      : out [N-1:0] signed, saturated quotient
//   overflow    : out magnitude did not fit and was clamped
module fixed_point_saturate
    import fixed_point_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int F = DEFAULT_F
) (
    input  logic [N+F-1:0] magnitude,
    input  logic           negative,
    input  logic           div_by_zero,
    output logic [N-1:0]   result,
    output logic           overflow
);

    // Largest representable positive magnitude and negative magnitude
    localparam logic [N+F-1:0] POS_LIMIT = {{(F+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [N+F-1:0] NEG_LIMIT = {{F{1'b0}}, 1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]   MAX_Q     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]   MIN_Q     = {1'b1, {(N-1){1'b0}}};

    // A divide-by-zero result takes the extreme of the dividend's sign and
    // is not reported as overflow. A negative magnitude of exactly 2^(N-1)
    // is still representable, so only larger magnitudes clamp.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        if (div_by_zero) begin
            result = negative ? MIN_Q : MAX_Q;
        end else if (negative) begin
            if (magnitude > NEG_LIMIT) begin
                result   = MIN_Q;
                overflow = 1'b1;
            end else begin
                result = ~magnitude[N-1:0] + 1'b1;
            end
        end else begin
            if (magnitude > POS_LIMIT) begin
                result   = MAX_Q;
                overflow = 1'b1;
            end else begin
                result = magnitude[N-1:0];
            end
        end
    end

endmodule

// File: rtl/fixed_point_divider.sv
// fixed_point_divider
// Sequential signed Q(N-F).F divider: quotient = sat(trunc((dividend<<F)/divisor)).
// Unsigned restoring division, one quotient bit per clock over N+F cycles.
//   clk      : in  clock, rising edge
//   reset    : in  synchronous active-high reset, aborts any division
//   start    : in  division request, only honoured while idle
//   dividend : in  [N-1:0] signed numerator, captured with start
//   divisor  : in  [N-1:0] signed denominator, captured with start
//   quotient : out [N-1:0] signed result, held until replaced
//   busy     : out high from the cycle after acceptance through the done cycle
//   done     : out one-cycle pulse when quotient/dbz/ovf are valid
//   dbz      : out divisor was zero for the current result
//   ovf      : out current result was saturated
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int F = DEFAULT_F
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic         busy,
    output logic         done,
    output logic         dbz,
    output logic         ovf
);

    localparam int               CNT_W    = $clog2(N + F + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N + F - 1);

    div_state_t       state;
    div_state_t       state_next;

    logic [N-1:0]     div_mag;
    logic [N+F-1:0]   acc;
    logic [N-1:0]     rem;
    logic             neg;
    logic             zero_div;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     dividend_mag;
    logic [N-1:0]     divisor_mag;
    logic [N:0]       trial;
    logic             take;
    logic [N-1:0]     rem_next;
    logic [N-1:0]     sat_q;
    logic             sat_ovf;

    // N-bit unsigned magnitudes; -2^(N-1) negates to itself, which reads
    // correctly as 2^(N-1) once treated as unsigned.
    assign dividend_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
    assign divisor_mag  = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;

    // Restoring step: shift the next numerator bit into the partial
    // remainder and subtract the divisor whenever it fits. acc shifts the
    // numerator out of its top while quotient bits enter at the bottom.
    assign trial    = {rem, acc[N+F-1]};
    assign take     = (trial >= {1'b0, div_mag});
    assign rem_next = take ? N'(trial - {1'b0, div_mag}) : trial[N-1:0];

    fixed_point_saturate #(
        .N (N),
        .F (F)
    ) u_saturate (
        .magnitude   (acc),
        .negative    (neg),
        .div_by_zero (zero_div),
        .result      (sat_q),
        .overflow    (sat_ovf)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero divisor skips the iterations entirely
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            div_mag  <= '0;
            acc      <= '0;
            rem      <= '0;
            neg      <= 1'b0;
            zero_div <= 1'b0;
            cnt      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        div_mag  <= divisor_mag;
                        acc      <= {dividend_mag, {F{1'b0}}};
                        rem      <= '0;
                        neg      <= dividend[N-1] ^ divisor[N-1];
                        zero_div <= (divisor == '0);
                        cnt      <= '0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= {acc[N+F-2:0], take};
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient <= sat_q;
                    ovf      <= sat_ovf;
                    dbz      <= zero_div;
                    done     <= 1'b1;
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider
// Directed and randomized checks of fixed_point_divider against an
// arithmetic reference model of the Q6.10 division with saturation.
module tb_fixed_point_divider;

    localparam int N = 16;
    localparam int F = 10;
    localparam logic [N-1:0] QMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] QMIN = {1'b1, {(N-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] quotient;
    logic         busy;
    logic         done;
    logic         dbz;
    logic         ovf;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    fixed_point_divider #(
        .N (N),
        .F (F)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, truncating toward zero, then clamp
    function automatic void refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                     output logic [N-1:0] q, output logic ov,
                                     output logic dz);
        longint num;
        longint res;
        q  = '0;
        ov = 1'b0;
        dz = 1'b0;
        if (b == '0) begin
            dz = 1'b1;
            q  = ($signed(a) < 0) ? QMIN : QMAX;
        end else begin
            num = longint'($signed(a)) * (longint'(1) << F);
            res = num / longint'($signed(b));
            if (res > longint'((1 << (N - 1)) - 1)) begin
                q  = QMAX;
                ov = 1'b1;
            end else if (res < -longint'(1 << (N - 1))) begin
                q  = QMIN;
                ov = 1'b1;
            end else begin
                q = N'(res);
            end
        end
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns just after the accepting edge
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency counts edges with the accepting edge as edge 1
    task automatic waitDone(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] exp_q,
                               input logic exp_ovf, input logic exp_dbz,
                               input int lat, input int exp_lat);
        checkValue({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        checkValue({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        checkValue({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        checkValue({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
        checkValue({tag, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        checkValue({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_q, input logic exp_ovf,
                         input logic exp_dbz, input int exp_lat);
        int lat;
        applyStimulus(a, b);
        waitDone(lat);
        checkOutput(tag, exp_q, exp_ovf, exp_dbz, lat, exp_lat);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic         eo;
        logic         ed;
        int           lat;
        int           done_seen;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("reset_quotient", 32'(quotient), 32'd0);
        checkValue("reset_busy", 32'(busy), 32'd0);
        checkValue("reset_done", 32'(done), 32'd0);
        checkValue("reset_dbz", 32'(dbz), 32'd0);
        checkValue("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] directed cases");
        runOp("three_by_two", 16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0, N + F + 2);
        runOp("one_third", 16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0, N + F + 2);
        runOp("neg_one_third", 16'hFC00, 16'h0C00, 16'hFEAB, 1'b0, 1'b0, N + F + 2);
        runOp("pos_sat", 16'h7C00, 16'h0200, 16'h7FFF, 1'b1, 1'b0, N + F + 2);
        runOp("min_by_neg_one", 16'h8000, 16'hFC00, 16'h7FFF, 1'b1, 1'b0, N + F + 2);
        runOp("min_by_one", 16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0, N + F + 2);
        runOp("zero_dividend", 16'h0000, 16'hF300, 16'h0000, 1'b0, 1'b0, N + F + 2);
        runOp("dbz_pos", 16'h0400, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 2);
        runOp("dbz_neg", 16'hFC00, 16'h0000, 16'h8000, 1'b0, 1'b1, 2);

        $display("[TB] reset during RUN");
        applyStimulus(16'h0C00, 16'h0800);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkValue("abort_quotient", 32'(quotient), 32'd0);
        checkValue("abort_busy", 32'(busy), 32'd0);
        checkValue("abort_done", 32'(done), 32'd0);
        checkValue("abort_dbz", 32'(dbz), 32'd0);
        checkValue("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        checkValue("abort_no_done", 32'(done_seen), 32'd0);
        runOp("after_abort", 16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0, N + F + 2);

        $display("[TB] start held high");
        @(negedge clk);
        dividend = 16'h0C00;
        divisor  = 16'h0800;
        start    = 1'b1;
        @(posedge clk);
        #1;
        waitDone(lat);
        checkValue("held_first_latency", 32'(lat), 32'(N + F + 2));
        checkValue("held_first_quotient", 32'(quotient), 32'h0600);
        @(negedge clk);
        dividend = 16'hFC00;
        divisor  = 16'h0C00;
        @(posedge clk);
        #1;
        checkValue("held_ignored_in_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkValue("held_accepted_after_done", 32'(busy), 32'd1);
        waitDone(lat);
        checkOutput("held_second", 16'hFEAB, 1'b0, 1'b0, lat, N + F + 2);

        $display("[TB] randomized cases");
        for (int i = 0; i < 24; i++) begin
            a = N'($urandom);
            b = N'($urandom);
            case (i % 4)
                1: b = N'($urandom_range(0, 3));
                2: b = {{(N-8){b[7]}}, b[7:0]};
                3: if (i % 8 == 3) a = QMIN;
                default: ;
            endcase
            refModel(a, b, eq, eo, ed);
            runOp($sformatf("rand%0d", i), a, b, eq, eo, ed, ed ? 2 : N + F + 2);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
